// File: rtl/dp_pkg.sv
// Shared encodings for the parametrised multicycle datapath: ALU operations
// and the select codes of the PC, register-write and ALU-B multiplexers.
package dp_pkg;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_SLL   = 3'd5;
    localparam logic [2:0] ALU_SRL   = 3'd6;
    localparam logic [2:0] ALU_PASSB = 3'd7;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_A      = 2'd3;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_LUI    = 2'd2;
    localparam logic [1:0] WD_LCD    = 2'd3;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_IMM2 = 2'd3;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU; shifts act on operand a by one bit, SLT compares signed.
module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_SLT:   y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL:   y = {a[WIDTH-2:0], 1'b0};
            ALU_SRL:   y = {1'b0, a[WIDTH-1:1]};
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/param_data_path.sv
// Multicycle datapath: PC/IR/A/B/ALUOut/MDR, register file, LCD register and a
// memory handshake that freezes all architectural state while the access waits.
module param_data_path
    import dp_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NREGS       = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               MEM_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             PCWriteBeq,
    input  logic             PCWriteBne,
    input  logic [1:0]       PCData,
    input  logic             IorD,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             IRegWrite,
    input  logic             RegWrite,
    input  logic             LCDWrite,
    input  logic             WriteAddr,
    input  logic [1:0]       WriteData,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic             SignExt,
    input  logic [2:0]       ALUOp,
    input  logic [WIDTH-1:0] LCDIn,
    input  logic [WIDTH-1:0] MemRData,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWe,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWData,
    output logic             Stall,
    output logic             Zero,
    output logic [WIDTH-1:0] LCDOut,
    output logic             MemError
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int HW = WIDTH / 2;

    logic [WIDTH-1:0] pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q, lcd_q;
    logic [WIDTH-1:0] regs [NREGS];
    logic [CW-1:0]    wait_cnt;
    logic             mem_err_q;

    logic [AW-1:0]    rs, rt, rd, waddr;
    logic [HW-1:0]    imm;
    logic [WIDTH-1:0] imm_ext, src_a, src_b, alu_y, pc_next, wd, rdata;
    logic             timeout, pc_en;

    assign rs  = ir_q[WIDTH-5 -: AW];
    assign rt  = ir_q[WIDTH-5-AW -: AW];
    assign rd  = ir_q[WIDTH-5-2*AW -: AW];
    assign imm = ir_q[HW-1:0];

    assign imm_ext = SignExt ? {{(WIDTH-HW){imm[HW-1]}}, imm} : {{(WIDTH-HW){1'b0}}, imm};
    assign src_a   = ALUSrcA ? a_q : pc_q;

    always_comb begin
        src_b = b_q;
        case (ALUSrcB)
            SRCB_B:    src_b = b_q;
            SRCB_ONE:  src_b = {{(WIDTH-1){1'b0}}, 1'b1};
            SRCB_IMM:  src_b = imm_ext;
            SRCB_IMM2: src_b = {imm_ext[WIDTH-2:0], 1'b0};
            default:   src_b = b_q;
        endcase
    end

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (src_a),
        .b  (src_b),
        .op (ALUOp),
        .y  (alu_y)
    );

    assign Zero = (alu_y == '0);

    // The access gives up after MEM_TIMEOUT waited cycles and completes with zero data.
    assign MemReq   = MemRead | MemWrite;
    assign MemWe    = MemWrite;
    assign timeout  = MemReq & ~MemReady & (wait_cnt == CW'(MEM_TIMEOUT));
    assign Stall    = MemReq & ~MemReady & ~timeout;
    assign rdata    = timeout ? '0 : MemRData;
    assign MemAddr  = IorD ? alu_out_q : pc_q;
    assign MemWData = b_q;
    assign LCDOut   = lcd_q;
    assign MemError = mem_err_q;

    assign pc_en = PCWrite | (PCWriteBeq & Zero) | (PCWriteBne & ~Zero);

    always_comb begin
        pc_next = alu_y;
        case (PCData)
            PC_ALU:    pc_next = alu_y;
            PC_ALUOUT: pc_next = alu_out_q;
            PC_JUMP:   pc_next = {pc_q[WIDTH-1:WIDTH-4], ir_q[WIDTH-5:0]};
            PC_A:      pc_next = a_q;
            default:   pc_next = alu_y;
        endcase
    end

    always_comb begin
        wd = alu_out_q;
        case (WriteData)
            WD_ALUOUT: wd = alu_out_q;
            WD_MDR:    wd = mdr_q;
            WD_LUI:    wd = {imm, {(WIDTH-HW){1'b0}}};
            WD_LCD:    wd = LCDIn;
            default:   wd = alu_out_q;
        endcase
    end

    assign waddr = WriteAddr ? rd : rt;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            wait_cnt <= Stall ? wait_cnt + 1'b1 : '0;
            if (timeout)
                mem_err_q <= 1'b1;
        end
    end

    // Register reads use pre-edge contents, so a same-cycle write is not forwarded.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            lcd_q     <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (!Stall) begin
            a_q       <= regs[rs];
            b_q       <= regs[rt];
            alu_out_q <= alu_y;
            mdr_q     <= rdata;
            if (IRegWrite)
                ir_q <= rdata;
            if (pc_en)
                pc_q <= pc_next;
            if (LCDWrite)
                lcd_q <= b_q;
            if (RegWrite && waddr != '0)
                regs[waddr] <= wd;
        end
    end

endmodule
